pipeline_layer_ctrl_bank: RTL and testbench

PIPELINE_LAYER_CTRL_BANK -- requirements
Module: pipeline_layer_ctrl_bank

---
 rtl/pipeline_ctrl_pkg.sv | 39 +++
 rtl/pipeline_layer_ctrl_regs.sv | 132 +++++++++++++
 rtl/pipeline_layer_ctrl_bank.sv | 165 ++++++++++++++++
 tb/tb_pipeline_layer_ctrl_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the layer control bank.
// Holds the register index map, the width-independent field widths, the bus
// widths of the write/readback ports and the reset defaults of every field.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 4;
  localparam int WR_DATA_W = 16;
  localparam int RD_DATA_W = 16;
  localparam int NUM_REGS  = 10;

  // Register index map (wr_reg / rd_reg)
  localparam logic [REG_IDX_W-1:0] REG_OVERLAY_MODE = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_FG_SCALE     = 4'd1;
  localparam logic [REG_IDX_W-1:0] REG_OFFSET_X     = 4'd2;
  localparam logic [REG_IDX_W-1:0] REG_OFFSET_Y     = 4'd3;
  localparam logic [REG_IDX_W-1:0] REG_TRANSPARENCY = 4'd4;
  localparam logic [REG_IDX_W-1:0] REG_GREEN_FILTER = 4'd5;
  localparam logic [REG_IDX_W-1:0] REG_CLIP_LEFT    = 4'd6;
  localparam logic [REG_IDX_W-1:0] REG_CLIP_RIGHT   = 4'd7;
  localparam logic [REG_IDX_W-1:0] REG_CLIP_TOP     = 4'd8;
  localparam logic [REG_IDX_W-1:0] REG_CLIP_BOTTOM  = 4'd9;
  localparam logic [REG_IDX_W-1:0] REG_LAST         = REG_CLIP_BOTTOM;

  // Fixed field widths; the remaining widths follow the module parameters
  localparam int OVERLAY_MODE_W = 2;
  localparam int FG_SCALE_W     = 2;

  // Offsets carry one extra bit over the screen coordinate for the sign
  function automatic int offset_w(input int precision);
    return precision + 1;
  endfunction

  // Reset defaults
  localparam logic [OVERLAY_MODE_W-1:0] OVERLAY_MODE_RST = '0;
  localparam logic [FG_SCALE_W-1:0]     FG_SCALE_RST     = '0;
  // RGB565 key colour: R=8, G=40, B=8
  localparam logic [15:0]               GREEN_FILTER_RST = {5'd8, 6'd40, 5'd8};

endpackage

// File: rtl/pipeline_layer_ctrl_regs.sv
// One layer's control set: a shadow copy written by the register port and an
// active copy that drives the layer outputs. The active copy is loaded from
// the shadow copy in one shot when commit is high.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_reg/wr_data shadow write (address already validated by the bank)
//   commit              copy shadow -> active on this edge
//   rd_reg/rd_active    readback select, rd_value zero-extended (combinational)
//   overlay_mode .. clip_bottom   active field values
module pipeline_layer_ctrl_regs
  import pipeline_ctrl_pkg::*;
#(
  parameter int PRECISION              = 11,
  parameter int PIXEL_SIZE             = 16,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [REG_IDX_W-1:0]              wr_reg,
  input  logic [WR_DATA_W-1:0]              wr_data,
  input  logic                              commit,
  input  logic [REG_IDX_W-1:0]              rd_reg,
  input  logic                              rd_active,
  output logic [RD_DATA_W-1:0]              rd_value,
  output logic [OVERLAY_MODE_W-1:0]         overlay_mode,
  output logic [FG_SCALE_W-1:0]             fg_scale,
  output logic [PRECISION:0]                offset_x,
  output logic [PRECISION:0]                offset_y,
  output logic [TRANSPARENCY_PRECISION-1:0] transparency,
  output logic [PIXEL_SIZE-1:0]             green_filter,
  output logic [PRECISION-1:0]              clip_left,
  output logic [PRECISION-1:0]              clip_right,
  output logic [PRECISION-1:0]              clip_top,
  output logic [PRECISION-1:0]              clip_bottom
);

  localparam int OFF_W = offset_w(PRECISION);

  // Offsets are held as raw two's-complement bits so readback zero-extends
  typedef struct packed {
    logic [OVERLAY_MODE_W-1:0]         overlay_mode;
    logic [FG_SCALE_W-1:0]             fg_scale;
    logic [OFF_W-1:0]                  offset_x;
    logic [OFF_W-1:0]                  offset_y;
    logic [TRANSPARENCY_PRECISION-1:0] transparency;
    logic [PIXEL_SIZE-1:0]             green_filter;
    logic [PRECISION-1:0]              clip_left;
    logic [PRECISION-1:0]              clip_right;
    logic [PRECISION-1:0]              clip_top;
    logic [PRECISION-1:0]              clip_bottom;
  } fields_t;

  localparam fields_t FIELDS_RST = '{
    overlay_mode: OVERLAY_MODE_RST,
    fg_scale:     FG_SCALE_RST,
    offset_x:     '0,
    offset_y:     '0,
    transparency: '0,
    green_filter: PIXEL_SIZE'(GREEN_FILTER_RST),
    clip_left:    '0,
    clip_right:   '0,
    clip_top:     '0,
    clip_bottom:  '0
  };

  fields_t shadow_q, shadow_d;
  fields_t active_q, active_d;
  fields_t rd_sel;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      case (wr_reg)
        REG_OVERLAY_MODE: shadow_d.overlay_mode = wr_data[OVERLAY_MODE_W-1:0];
        REG_FG_SCALE:     shadow_d.fg_scale     = wr_data[FG_SCALE_W-1:0];
        REG_OFFSET_X:     shadow_d.offset_x     = wr_data[OFF_W-1:0];
        REG_OFFSET_Y:     shadow_d.offset_y     = wr_data[OFF_W-1:0];
        REG_TRANSPARENCY: shadow_d.transparency = wr_data[TRANSPARENCY_PRECISION-1:0];
        REG_GREEN_FILTER: shadow_d.green_filter = wr_data[PIXEL_SIZE-1:0];
        REG_CLIP_LEFT:    shadow_d.clip_left    = wr_data[PRECISION-1:0];
        REG_CLIP_RIGHT:   shadow_d.clip_right   = wr_data[PRECISION-1:0];
        REG_CLIP_TOP:     shadow_d.clip_top     = wr_data[PRECISION-1:0];
        REG_CLIP_BOTTOM:  shadow_d.clip_bottom  = wr_data[PRECISION-1:0];
        default:          shadow_d = shadow_q;
      endcase
    end
    // A commit never coincides with a write (the bank stalls writes while
    // committing), so the whole set moves atomically.
    active_d = commit ? shadow_q : active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= FIELDS_RST;
      active_q <= FIELDS_RST;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    rd_sel   = rd_active ? active_q : shadow_q;
    rd_value = '0;
    case (rd_reg)
      REG_OVERLAY_MODE: rd_value = RD_DATA_W'(rd_sel.overlay_mode);
      REG_FG_SCALE:     rd_value = RD_DATA_W'(rd_sel.fg_scale);
      REG_OFFSET_X:     rd_value = RD_DATA_W'(rd_sel.offset_x);
      REG_OFFSET_Y:     rd_value = RD_DATA_W'(rd_sel.offset_y);
      REG_TRANSPARENCY: rd_value = RD_DATA_W'(rd_sel.transparency);
      REG_GREEN_FILTER: rd_value = RD_DATA_W'(rd_sel.green_filter);
      REG_CLIP_LEFT:    rd_value = RD_DATA_W'(rd_sel.clip_left);
      REG_CLIP_RIGHT:   rd_value = RD_DATA_W'(rd_sel.clip_right);
      REG_CLIP_TOP:     rd_value = RD_DATA_W'(rd_sel.clip_top);
      REG_CLIP_BOTTOM:  rd_value = RD_DATA_W'(rd_sel.clip_bottom);
      default:          rd_value = '0;
    endcase
  end

  assign overlay_mode = active_q.overlay_mode;
  assign fg_scale     = active_q.fg_scale;
  assign offset_x     = active_q.offset_x;
  assign offset_y     = active_q.offset_y;
  assign transparency = active_q.transparency;
  assign green_filter = active_q.green_filter;
  assign clip_left    = active_q.clip_left;
  assign clip_right   = active_q.clip_right;
  assign clip_top     = active_q.clip_top;
  assign clip_bottom  = active_q.clip_bottom;

endmodule

// File: rtl/pipeline_layer_ctrl_bank.sv
// Double-buffered control register bank for the foreground layers of the
// pixel pipeline. Software writes shadow registers at any time; a commit
// (immediate, or deferred to the next frame start) copies every layer's
// shadow set into its active set in a single edge so the pipeline never sees
// a half-updated configuration.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   wr_valid/wr_ready, wr_layer, wr_reg, wr_data   shadow write port
//   commit_req, commit_now            deferred / immediate commit pulses
//   pixel_x, pixel_y, pixel_ready     frame-start detection
//   rd_layer, rd_reg, rd_active, rd_data           registered readback
//   ctrl_*                            flattened active fields, layer k in slice k
//   commit_pending, commit_done, commit_count, err_bad_addr   status
module pipeline_layer_ctrl_bank
  import pipeline_ctrl_pkg::*;
#(
  parameter int  NUM_LAYERS             = 2,
  parameter int  PRECISION              = 11,
  parameter int  PIXEL_SIZE             = 16,
  parameter int  TRANSPARENCY_PRECISION = 3,
  localparam int LAYER_W                = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [LAYER_W-1:0]                           wr_layer,
  input  logic [REG_IDX_W-1:0]                         wr_reg,
  input  logic [WR_DATA_W-1:0]                         wr_data,
  input  logic                                         commit_req,
  input  logic                                         commit_now,
  input  logic [PRECISION-1:0]                         pixel_x,
  input  logic [PRECISION-1:0]                         pixel_y,
  input  logic                                         pixel_ready,
  input  logic [LAYER_W-1:0]                           rd_layer,
  input  logic [REG_IDX_W-1:0]                         rd_reg,
  input  logic                                         rd_active,
  output logic [RD_DATA_W-1:0]                         rd_data,
  output logic [OVERLAY_MODE_W*NUM_LAYERS-1:0]         ctrl_overlay_mode,
  output logic [FG_SCALE_W*NUM_LAYERS-1:0]             ctrl_fg_scale,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
  output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
  output logic [PIXEL_SIZE*NUM_LAYERS-1:0]             ctrl_green_screen_filter,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_left,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_right,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_top,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_bottom,
  output logic                                         commit_pending,
  output logic                                         commit_done,
  output logic [7:0]                                   commit_count,
  output logic                                         err_bad_addr
);

  localparam int OFF_W = offset_w(PRECISION);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 commit_done_q, commit_done_d;
  logic [7:0]           commit_count_q, commit_count_d;
  logic                 err_bad_addr_q, err_bad_addr_d;
  logic [RD_DATA_W-1:0] rd_data_q, rd_data_d;

  logic                 in_commit;
  logic                 wr_fire;
  logic                 wr_addr_ok;
  logic                 frame_start;
  logic [RD_DATA_W-1:0] layer_rd [NUM_LAYERS];

  assign in_commit   = (state_q == ST_COMMIT);
  // Writes stall only in the commit cycle, so a write landing on the edge
  // that enters COMMIT is already in the shadow set when the copy happens.
  assign wr_ready    = !in_commit;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_addr_ok  = (wr_reg <= REG_LAST) && (int'(wr_layer) < NUM_LAYERS);
  assign frame_start = pixel_ready && (pixel_x == '0) && (pixel_y == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_now)      state_d = ST_COMMIT;
        else if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (commit_now || frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // Requests arriving during the commit are queued, not dropped
        if (commit_now)      state_d = ST_COMMIT;
        else if (commit_req) state_d = ST_PENDING;
        else                 state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    commit_done_d  = in_commit;
    commit_count_d = commit_count_q + 8'(in_commit);
    err_bad_addr_d = err_bad_addr_q | (wr_fire & ~wr_addr_ok);
  end

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (int'(rd_layer) == k) rd_data_d = layer_rd[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      commit_done_q  <= 1'b0;
      commit_count_q <= '0;
      err_bad_addr_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      commit_done_q  <= commit_done_d;
      commit_count_q <= commit_count_d;
      err_bad_addr_q <= err_bad_addr_d;
      rd_data_q      <= rd_data_d;
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic layer_wr_en;
    assign layer_wr_en = wr_fire && wr_addr_ok && (int'(wr_layer) == k);

    pipeline_layer_ctrl_regs #(
      .PRECISION              (PRECISION),
      .PIXEL_SIZE             (PIXEL_SIZE),
      .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION)
    ) u_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (layer_wr_en),
      .wr_reg       (wr_reg),
      .wr_data      (wr_data),
      .commit       (in_commit),
      .rd_reg       (rd_reg),
      .rd_active    (rd_active),
      .rd_value     (layer_rd[k]),
      .overlay_mode (ctrl_overlay_mode[OVERLAY_MODE_W*k +: OVERLAY_MODE_W]),
      .fg_scale     (ctrl_fg_scale[FG_SCALE_W*k +: FG_SCALE_W]),
      .offset_x     (ctrl_fg_offset_x[OFF_W*k +: OFF_W]),
      .offset_y     (ctrl_fg_offset_y[OFF_W*k +: OFF_W]),
      .transparency (ctrl_fg_transparency[TRANSPARENCY_PRECISION*k +: TRANSPARENCY_PRECISION]),
      .green_filter (ctrl_green_screen_filter[PIXEL_SIZE*k +: PIXEL_SIZE]),
      .clip_left    (ctrl_fg_clip_left[PRECISION*k +: PRECISION]),
      .clip_right   (ctrl_fg_clip_right[PRECISION*k +: PRECISION]),
      .clip_top     (ctrl_fg_clip_top[PRECISION*k +: PRECISION]),
      .clip_bottom  (ctrl_fg_clip_bottom[PRECISION*k +: PRECISION])
    );
  end

  assign commit_pending = (state_q == ST_PENDING);
  assign commit_done    = commit_done_q;
  assign commit_count   = commit_count_q;
  assign err_bad_addr   = err_bad_addr_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_pipeline_layer_ctrl_bank.sv
`timescale 1ns/1ps
module tb_pipeline_layer_ctrl_bank;

  localparam int NL   = 2;
  localparam int PREC = 11;
  localparam int OFFW = PREC + 1;
  localparam int TP   = 3;
  localparam int PIX  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        wr_valid, wr_ready;
  logic [0:0]  wr_layer;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        commit_req, commit_now;
  logic [PREC-1:0] pixel_x, pixel_y;
  logic        pixel_ready;
  logic [0:0]  rd_layer;
  logic [3:0]  rd_reg;
  logic        rd_active;
  logic [15:0] rd_data;
  logic [2*NL-1:0]    ctrl_overlay_mode, ctrl_fg_scale;
  logic [OFFW*NL-1:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
  logic [TP*NL-1:0]   ctrl_fg_transparency;
  logic [PIX*NL-1:0]  ctrl_green_screen_filter;
  logic [PREC*NL-1:0] ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom;
  logic        commit_pending, commit_done, err_bad_addr;
  logic [7:0]  commit_count;

  pipeline_layer_ctrl_bank dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_layer(wr_layer), .wr_reg(wr_reg), .wr_data(wr_data),
    .commit_req(commit_req), .commit_now(commit_now),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_ready(pixel_ready),
    .rd_layer(rd_layer), .rd_reg(rd_reg), .rd_active(rd_active), .rd_data(rd_data),
    .ctrl_overlay_mode(ctrl_overlay_mode), .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_offset_x(ctrl_fg_offset_x), .ctrl_fg_offset_y(ctrl_fg_offset_y),
    .ctrl_fg_transparency(ctrl_fg_transparency), .ctrl_green_screen_filter(ctrl_green_screen_filter),
    .ctrl_fg_clip_left(ctrl_fg_clip_left), .ctrl_fg_clip_right(ctrl_fg_clip_right),
    .ctrl_fg_clip_top(ctrl_fg_clip_top), .ctrl_fg_clip_bottom(ctrl_fg_clip_bottom),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .commit_count(commit_count), .err_bad_addr(err_bad_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fields kept as plain per-layer, per-register values; a commit is a bulk
  // array copy. Control is described by two facts: "a commit is waiting for
  // frame start" and "the copy happens at the coming edge".
  logic [15:0] m_sh [NL][10];
  logic [15:0] m_ac [NL][10];
  bit          m_pend, m_copy_next, m_done, m_err;
  logic [7:0]  m_cnt;
  logic [15:0] m_rd;

  function automatic logic [15:0] fmask(input int r);
    case (r)
      0, 1:    return 16'h0003;
      2, 3:    return 16'h0FFF;
      4:       return 16'h0007;
      5:       return 16'hFFFF;
      default: return 16'h07FF;
    endcase
  endfunction

  task automatic m_reset();
    for (int l = 0; l < NL; l++)
      for (int r = 0; r < 10; r++) begin
        m_sh[l][r] = (r == 5) ? 16'h4508 : 16'h0000;
        m_ac[l][r] = m_sh[l][r];
      end
    m_pend = 0; m_copy_next = 0; m_done = 0; m_err = 0; m_cnt = 0; m_rd = 0;
  endtask

  task automatic m_step();
    int rl, rr, wl, wrg;
    bit fs, accept;
    logic [15:0] rd_n;
    rl = int'(rd_layer); rr = int'(rd_reg);
    wl = int'(wr_layer); wrg = int'(wr_reg);
    rd_n = 16'h0;
    if (rl < NL && rr <= 9) rd_n = rd_active ? m_ac[rl][rr] : m_sh[rl][rr];
    accept = wr_valid && !m_copy_next;
    m_done = m_copy_next;
    if (m_copy_next) begin
      m_ac = m_sh;
      m_cnt = m_cnt + 8'd1;
    end
    if (accept) begin
      if (wrg > 9 || wl >= NL) m_err = 1;
      else m_sh[wl][wrg] = wr_data & fmask(wrg);
    end
    fs = pixel_ready && pixel_x == 0 && pixel_y == 0;
    if (m_copy_next) begin
      m_copy_next = commit_now;
      m_pend = !commit_now && commit_req;
    end else if (m_pend) begin
      if (commit_now || fs) begin m_copy_next = 1; m_pend = 0; end
    end else begin
      if (commit_now) m_copy_next = 1;
      else if (commit_req) m_pend = 1;
    end
    m_rd = rd_n;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2*NL-1:0]    e_mode, e_scale;
  logic [OFFW*NL-1:0] e_offx, e_offy;
  logic [TP*NL-1:0]   e_trans;
  logic [PIX*NL-1:0]  e_green;
  logic [PREC*NL-1:0] e_cl, e_cr, e_ct, e_cb;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int l = 0; l < NL; l++) begin
        e_mode[2*l +: 2]       = m_ac[l][0][1:0];
        e_scale[2*l +: 2]      = m_ac[l][1][1:0];
        e_offx[OFFW*l +: OFFW] = m_ac[l][2][OFFW-1:0];
        e_offy[OFFW*l +: OFFW] = m_ac[l][3][OFFW-1:0];
        e_trans[TP*l +: TP]    = m_ac[l][4][TP-1:0];
        e_green[PIX*l +: PIX]  = m_ac[l][5];
        e_cl[PREC*l +: PREC]   = m_ac[l][6][PREC-1:0];
        e_cr[PREC*l +: PREC]   = m_ac[l][7][PREC-1:0];
        e_ct[PREC*l +: PREC]   = m_ac[l][8][PREC-1:0];
        e_cb[PREC*l +: PREC]   = m_ac[l][9][PREC-1:0];
      end
      check("wr_ready", 64'(wr_ready), 64'(!m_copy_next));
      check("commit_pending", 64'(commit_pending), 64'(m_pend));
      check("commit_done", 64'(commit_done), 64'(m_done));
      check("commit_count", 64'(commit_count), 64'(m_cnt));
      check("err_bad_addr", 64'(err_bad_addr), 64'(m_err));
      check("rd_data", 64'(rd_data), 64'(m_rd));
      check("overlay_mode", 64'(ctrl_overlay_mode), 64'(e_mode));
      check("fg_scale", 64'(ctrl_fg_scale), 64'(e_scale));
      check("offset_x", 64'(ctrl_fg_offset_x), 64'(e_offx));
      check("offset_y", 64'(ctrl_fg_offset_y), 64'(e_offy));
      check("transparency", 64'(ctrl_fg_transparency), 64'(e_trans));
      check("green_filter", 64'(ctrl_green_screen_filter), 64'(e_green));
      check("clip_left", 64'(ctrl_fg_clip_left), 64'(e_cl));
      check("clip_right", 64'(ctrl_fg_clip_right), 64'(e_cr));
      check("clip_top", 64'(ctrl_fg_clip_top), 64'(e_ct));
      check("clip_bottom", 64'(ctrl_fg_clip_bottom), 64'(e_cb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_valid = 0; wr_layer = 0; wr_reg = 0; wr_data = 0;
    commit_req = 0; commit_now = 0;
    pixel_ready = 1; pixel_x = 7; pixel_y = 3;
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic write(input int l, input int r, input logic [15:0] d);
    wr_valid = 1; wr_layer = 1'(l); wr_reg = 4'(r); wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic frame_start_cycle();
    pixel_ready = 1; pixel_x = 0; pixel_y = 0;
    tick();
    pixel_x = 7; pixel_y = 3;
  endtask

  initial begin
    idle();
    rd_layer = 0; rd_reg = 0; rd_active = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #1;
    check("rst_green_both", 64'(ctrl_green_screen_filter), 64'h4508_4508);
    check("rst_wr_ready", 64'(wr_ready), 64'h1);
    check("rst_count", 64'(commit_count), 64'h0);
    check("rst_rd_data", 64'(rd_data), 64'h0);
    rst_n = 1;
    tick();

    // Layer 1 offset_x = -5, deferred commit
    rd_layer = 1; rd_reg = 2; rd_active = 0;
    write(1, 2, 16'hFFFB);
    check("shadow_rd_edge1", 64'(rd_data), 64'h0);
    tick();
    check("shadow_rd_edge2", 64'(rd_data), 64'h0FFB);
    commit_req = 1; tick(); commit_req = 0;
    repeat (4) tick();
    check("req_pending", 64'(commit_pending), 64'h1);
    check("req_offx_unchanged", 64'(ctrl_fg_offset_x[23:12]), 64'h0);
    frame_start_cycle();
    check("fs_edge1_offx", 64'(ctrl_fg_offset_x[23:12]), 64'h0);
    check("fs_edge1_wr_ready", 64'(wr_ready), 64'h0);
    tick();
    check("fs_edge2_offx", 64'(ctrl_fg_offset_x[23:12]), 64'hFFB);
    check("fs_count", 64'(commit_count), 64'h1);
    check("fs_done", 64'(commit_done), 64'h1);
    tick();
    check("fs_done_drop", 64'(commit_done), 64'h0);

    // Immediate commit of layer 0 clip_left = 100
    write(0, 6, 16'd100);
    commit_now = 1; tick(); commit_now = 0;
    check("now_edge1_clip", 64'(ctrl_fg_clip_left[10:0]), 64'h0);
    tick();
    check("now_edge2_clip", 64'(ctrl_fg_clip_left[10:0]), 64'd100);
    check("now_done", 64'(commit_done), 64'h1);
    tick();
    check("now_done_once", 64'(commit_done), 64'h0);

    // Bad register index
    write(0, 12, 16'h1234);
    check("bad_err", 64'(err_bad_addr), 64'h1);
    commit_now = 1; tick(); commit_now = 0;
    tick(); tick();
    check("bad_err_sticky", 64'(err_bad_addr), 64'h1);
    check("bad_count", 64'(commit_count), 64'h3);

    // Write on the frame-start edge while pending
    commit_req = 1; tick(); commit_req = 0;
    tick();
    check("p44_pending", 64'(commit_pending), 64'h1);
    wr_valid = 1; wr_layer = 0; wr_reg = 4; wr_data = 16'h0005;
    frame_start_cycle();
    wr_valid = 0;
    check("p44_wr_ready_low", 64'(wr_ready), 64'h0);
    tick();
    check("p44_wr_ready_back", 64'(wr_ready), 64'h1);
    check("p44_trans", 64'(ctrl_fg_transparency[2:0]), 64'h5);

    // Reset while pending
    write(1, 7, 16'd77);
    commit_req = 1; tick(); commit_req = 0;
    tick();
    check("p45_pending", 64'(commit_pending), 64'h1);
    #2 rst_n = 0;
    #1;
    check("p45_rst_pending", 64'(commit_pending), 64'h0);
    check("p45_rst_clip_r", 64'(ctrl_fg_clip_right), 64'h0);
    check("p45_rst_err", 64'(err_bad_addr), 64'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    rd_layer = 1; rd_reg = 7; rd_active = 0;
    tick();
    frame_start_cycle();
    tick(); tick();
    check("p45_no_commit", 64'(commit_count), 64'h0);
    check("p45_clip_r", 64'(ctrl_fg_clip_right), 64'h0);
    check("p45_shadow_gone", 64'(rd_data), 64'h0);

    // 256 back-to-back immediate commits
    commit_now = 1;
    repeat (256) tick();
    check("wrap_255", 64'(commit_count), 64'd255);
    commit_now = 0;
    tick();
    check("wrap_0", 64'(commit_count), 64'd0);
    tick();

    // Randomized traffic, with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_layer    = 1'($urandom_range(0, 1));
      wr_reg      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      wr_data     = 16'($urandom);
      commit_req  = ($urandom_range(0, 9) == 0);
      commit_now  = ($urandom_range(0, 19) == 0);
      pixel_ready = ($urandom_range(0, 1) == 1);
      pixel_x     = ($urandom_range(0, 7) == 0) ? '0 : PREC'($urandom_range(0, 3));
      pixel_y     = ($urandom_range(0, 3) == 0) ? '0 : PREC'($urandom_range(0, 2));
      rd_layer    = 1'($urandom_range(0, 1));
      rd_reg      = 4'($urandom_range(0, 11));
      rd_active   = 1'($urandom_range(0, 1));
      if (c == 700) begin
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
      end
      tick();
    end
    idle();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
